uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
Serial command receiver that sits directly upstream of the Team4 CPU's UART load port. It deserialises 8N1 bytes from the rx pin and assembles 3-byte command frames: a header carrying the select code, then data high byte, then data low byte. Each complete frame produces one single-cycle uart_en strobe with uart_sel/uart_data, the exact signals the CPU consumes.

Parameters:
CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); minimum 4.
TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one frame before the partial frame is discarded.
HDR_TAG, 6'b101000, required value of header bits [7:2].

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
uart_en  output  1  one-cycle strobe: uart_sel/uart_data hold a new command
uart_sel  output  2  command select = header bits [1:0]
uart_data  output  16  {high byte, low byte}
frame_err  output  1  one-cycle pulse on stop-bit error, bad header or inter-byte timeout
busy  output  1  high while a byte or partial frame is in progress

Behaviour:
- Reset (reset==0 sampled at posedge clk): uart_en=0, uart_sel=0, uart_data=0, frame_err=0, busy=0; synchroniser flops=1; both FSMs return to idle. Reset mid-byte or mid-frame discards everything with no strobe.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s==0 -> START; bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles (integer division). If rx_s==1 at that point it is a false start -> IDLE with no error; otherwise -> DATA.
  - DATA: sample at every CLKS_PER_BIT cycles, LSB first; after 8 samples -> STOP.
  - STOP: sample after CLKS_PER_BIT. rx_s==1 -> byte_valid pulse. rx_s==0 -> frame_err pulse, byte dropped, frame FSM forced to HDR. In both cases -> IDLE, without waiting for the line to go high. A line still low re-enters START only on the next cycle's check.
- Frame FSM states: HDR, HI, LO. It advances only on byte_valid.
  - HDR: byte[7:2]==HDR_TAG -> latch sel=byte[1:0] -> HI. Otherwise frame_err pulse and stay in HDR.
  - HI: latch high byte -> LO.
  - LO: on the cycle after the LO byte_valid, uart_en=1 for exactly one cycle, with uart_data={hi,lo} and uart_sel=sel updated in that same cycle. -> HDR.
- uart_sel/uart_data change only at a strobe and hold until the next one. Partial frames never disturb them.
- Timeout: in HI or LO with bit FSM in IDLE, a counter runs. When it reaches TIMEOUT_BITS*CLKS_PER_BIT cycles: frame_err pulse, -> HDR. The counter clears on every start-bit detection.
- busy = (bit FSM != IDLE) || (frame FSM != HDR).
- Simultaneous stop-bit error and timeout cannot occur, because the timeout only runs in IDLE. frame_err is never wider than one cycle.
- Throughput: back-to-back bytes with zero idle bits between them are received correctly.

Decomposition:
- Shared package uart_pkg: bit-state and frame-state enums, HDR_TAG default, UART_BYTE_W=8.
- One sub-module, uart_rx_byte: synchroniser, bit FSM and baud counter, with outputs byte_valid, byte_data and stop_err.
- Top level: frame FSM, timeout counter and output registers.

Test Plan:
All scenarios use CLKS_PER_BIT=8 and TIMEOUT_BITS=4.
- Send bytes A1,00,0A back-to-back -> exactly one uart_en pulse, uart_sel=1, uart_data=0x000A, frame_err never high.
- Send A2,00,64, then A1,12,34 -> two strobes: (2,0x0064) then (1,0x1234). Outputs hold their values between the strobes.
- Send header 5A, then A3,FF,FF -> frame_err pulse after 5A, then strobe with sel=3, data=0xFFFF.
- Send A1, then a byte with stop bit=0, then A1,00,07 -> frame_err pulse, no strobe from the corrupted frame, then strobe (1,0x0007).
- Send A1,00, then idle 40 cycles, then 0A -> frame_err pulse at timeout, no strobe, frame FSM back in HDR (0A is then rejected as a header with a further frame_err).
- Send a 2-cycle low glitch on rx -> no byte, no frame_err. Separately, assert reset for 1 cycle midway through the HI byte -> all outputs 0, busy=0, next full frame A1,00,05 strobes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command receiver.
// Holds the bit/frame state encodings and the header-tag check used by the frame FSM.
package uart_pkg;

    localparam int         UART_BYTE_W = 8;
    localparam logic [5:0] HDR_TAG_DEF = 6'b101000;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [1:0] {
        F_HDR = 2'd0,
        F_HI  = 2'd1,
        F_LO  = 2'd2
    } frame_state_t;

    function automatic logic hdr_ok(input logic [5:0] field, input logic [5:0] tag);
        return (field == tag);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, bit FSM and baud counter.
// Emits one-cycle byte_valid or stop_err pulses once the stop bit is sampled.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rx,
    output logic                   o_byte_valid,
    output logic [UART_BYTE_W-1:0] o_byte_data,
    output logic                   o_stop_err,
    output logic                   o_idle
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic                   r_sync1, r_sync2;
    bit_state_t             r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [2:0]             r_bit_cnt, w_bit_nxt;
    logic [UART_BYTE_W-1:0] r_shift, w_shift_nxt;
    logic                   r_byte_valid, w_valid_nxt;
    logic                   r_stop_err, w_err_nxt;
    logic                   w_rx_s;

    assign w_rx_s = r_sync2;

    // Synchroniser and bit-FSM state registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_state      <= B_IDLE;
            r_cnt        <= {CW{1'b0}};
            r_bit_cnt    <= 3'd0;
            r_shift      <= {UART_BYTE_W{1'b0}};
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_valid_nxt;
            r_stop_err   <= w_err_nxt;
        end
    end

    // Bit FSM: half-bit start qualification, then one sample per bit period.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            B_IDLE: begin
                w_cnt_nxt = {CW{1'b0}};
                w_bit_nxt = 3'd0;
                if (!w_rx_s) begin
                    w_state_nxt = B_START;
                end else begin
                    w_state_nxt = B_IDLE;
                end
            end
            B_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = w_rx_s ? B_IDLE : B_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            B_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt   = {CW{1'b0}};
                    w_shift_nxt = {w_rx_s, r_shift[UART_BYTE_W-1:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = B_STOP;
                    end else begin
                        w_state_nxt = B_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            B_STOP: begin
                if (r_cnt == FULL_M1) begin
                    // Return to IDLE at once so a following start bit is not missed.
                    w_cnt_nxt   = {CW{1'b0}};
                    w_state_nxt = B_IDLE;
                    w_valid_nxt = w_rx_s;
                    w_err_nxt   = !w_rx_s;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = B_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_shift;
    assign o_stop_err   = r_stop_err;
    assign o_idle       = (r_state == B_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: assembles header/high/low byte frames into one uart_en strobe.
// Owns the frame FSM, the inter-byte timeout and the registered CPU-facing outputs.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         TIMEOUT_BITS = 20,
    parameter logic [5:0] HDR_TAG      = HDR_TAG_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        uart_en,
    output logic [1:0]  uart_sel,
    output logic [15:0] uart_data,
    output logic        frame_err,
    output logic        busy
);
    localparam int            TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_M1    = TW'(TO_LIMIT - 1);
    localparam logic [TW-1:0] TO_ONE   = {{(TW-1){1'b0}}, 1'b1};

    logic                   w_byte_valid, w_stop_err, w_bit_idle;
    logic [UART_BYTE_W-1:0] w_byte;

    frame_state_t           r_frame, w_frame_nxt;
    logic [1:0]             r_sel, w_sel_nxt;
    logic [UART_BYTE_W-1:0] r_hi, w_hi_nxt;
    logic [TW-1:0]          r_to_cnt, w_to_nxt;
    logic                   r_uart_en, w_en_nxt;
    logic [1:0]             r_uart_sel, w_osel_nxt;
    logic [15:0]            r_uart_data, w_data_nxt;
    logic                   r_frame_err, w_err_nxt;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rx        (rx),
        .o_byte_valid(w_byte_valid),
        .o_byte_data (w_byte),
        .o_stop_err  (w_stop_err),
        .o_idle      (w_bit_idle)
    );

    // Frame state, timeout counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame     <= F_HDR;
            r_sel       <= 2'd0;
            r_hi        <= 8'h00;
            r_to_cnt    <= {TW{1'b0}};
            r_uart_en   <= 1'b0;
            r_uart_sel  <= 2'd0;
            r_uart_data <= 16'h0000;
            r_frame_err <= 1'b0;
        end else begin
            r_frame     <= w_frame_nxt;
            r_sel       <= w_sel_nxt;
            r_hi        <= w_hi_nxt;
            r_to_cnt    <= w_to_nxt;
            r_uart_en   <= w_en_nxt;
            r_uart_sel  <= w_osel_nxt;
            r_uart_data <= w_data_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    // Frame FSM; the timeout only counts while a frame is open and the line is idle.
    always_comb begin
        w_frame_nxt = r_frame;
        w_sel_nxt   = r_sel;
        w_hi_nxt    = r_hi;
        w_to_nxt    = r_to_cnt;
        w_en_nxt    = 1'b0;
        w_osel_nxt  = r_uart_sel;
        w_data_nxt  = r_uart_data;
        w_err_nxt   = 1'b0;
        if (w_stop_err) begin
            w_frame_nxt = F_HDR;
            w_err_nxt   = 1'b1;
            w_to_nxt    = {TW{1'b0}};
        end else if (w_byte_valid) begin
            w_to_nxt = {TW{1'b0}};
            case (r_frame)
                F_HDR: begin
                    if (hdr_ok(w_byte[7:2], HDR_TAG)) begin
                        w_sel_nxt   = w_byte[1:0];
                        w_frame_nxt = F_HI;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                F_HI: begin
                    w_hi_nxt    = w_byte;
                    w_frame_nxt = F_LO;
                end
                F_LO: begin
                    w_en_nxt    = 1'b1;
                    w_osel_nxt  = r_sel;
                    w_data_nxt  = {r_hi, w_byte};
                    w_frame_nxt = F_HDR;
                end
                default: begin
                    w_frame_nxt = F_HDR;
                end
            endcase
        end else if ((r_frame != F_HDR) && w_bit_idle) begin
            if (r_to_cnt == TO_M1) begin
                w_err_nxt   = 1'b1;
                w_frame_nxt = F_HDR;
                w_to_nxt    = {TW{1'b0}};
            end else begin
                w_to_nxt = r_to_cnt + TO_ONE;
            end
        end else begin
            w_to_nxt = {TW{1'b0}};
        end
    end

    assign uart_en   = r_uart_en;
    assign uart_sel  = r_uart_sel;
    assign uart_data = r_uart_data;
    assign frame_err = r_frame_err;
    assign busy      = !w_bit_idle || (r_frame != F_HDR);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: serial byte driver, frame-level reference model
// built on a pending-byte queue, and an output monitor that records strobes and error pulses.
module tb_uart_cmd_rx;
    localparam int CPB = 8;
    localparam int TOB = 4;

    logic        clk, reset, rx;
    logic        uart_en, frame_err, busy;
    logic [1:0]  uart_sel;
    logic [15:0] uart_data;

    int n_cmp = 0;
    int n_fail = 0;

    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    logic [7:0]  pend[$];
    int          got_err, exp_err, err_wide, hold_viol;
    logic        prev_err, prev_valid;
    logic [17:0] prev_out;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .uart_en(uart_en), .uart_sel(uart_sel),
        .uart_data(uart_data), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records strobes, error pulses, over-wide errors and output changes without a strobe.
    initial begin
        got_err = 0; err_wide = 0; hold_viol = 0;
        prev_err = 1'b0; prev_valid = 1'b0; prev_out = 18'h0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (uart_en) got_q.push_back({uart_sel, uart_data});
                if (frame_err) got_err++;
                if (frame_err && prev_err) err_wide++;
                if (!uart_en && prev_valid && ({uart_sel, uart_data} != prev_out)) hold_viol++;
                prev_valid = 1'b1;
            end else begin
                prev_valid = 1'b0;
            end
            prev_err = frame_err;
            prev_out = {uart_sel, uart_data};
        end
    end

    // Reference model: a frame is any header with the right tag followed by two bytes.
    task automatic mdl_byte(input logic [7:0] b);
        if (pend.size() == 0 && b[7:2] != 6'b101000) begin
            exp_err++;
        end else begin
            pend.push_back(b);
            if (pend.size() == 3) begin
                exp_q.push_back({pend[0][1:0], pend[1], pend[2]});
                pend.delete();
            end
        end
    endtask

    task automatic mdl_break();
        pend.delete();
        exp_err++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frm;
        frm = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frm[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic tx(input logic [7:0] b);
        send_byte(b, 1'b1);
        mdl_byte(b);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_test();
        got_q.delete(); exp_q.delete(); pend.delete();
        got_err = 0; exp_err = 0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s_busy_timeout: busy still %b after %0d cycles, required 0", name, busy, k);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; rx = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (uart_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b required 0", uart_en); end
        n_cmp++; if (uart_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d required 0", uart_sel); end
        n_cmp++; if (uart_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0000", uart_data); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_frame();
        start_test();
        tx(8'hA1); tx(8'h00); tx(8'h0A);
        wait_idle("single");
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
        end else foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_val[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_err != exp_err) begin n_fail++; $display("FAIL single_err: got %0d required %0d", got_err, exp_err); end
    endtask

    task automatic test_two_frames();
        start_test();
        tx(8'hA2); tx(8'h00); tx(8'h64);
        idle(30);
        tx(8'hA1); tx(8'h12); tx(8'h34);
        wait_idle("two");
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL two_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
        end else foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL two_val[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_err != exp_err) begin n_fail++; $display("FAIL two_err: got %0d required %0d", got_err, exp_err); end
        n_cmp++;
        if ({uart_sel, uart_data} !== exp_q[exp_q.size()-1]) begin
            n_fail++; $display("FAIL two_hold: got %h required %h", {uart_sel, uart_data}, exp_q[exp_q.size()-1]);
        end
    endtask

    task automatic test_bad_header();
        start_test();
        tx(8'h5A);
        tx(8'hA3); tx(8'hFF); tx(8'hFF);
        wait_idle("badhdr");
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL badhdr_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
        end else foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badhdr_val[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_err != exp_err) begin n_fail++; $display("FAIL badhdr_err: got %0d required %0d", got_err, exp_err); end
    endtask

    task automatic test_stop_err();
        start_test();
        tx(8'hA1);
        send_byte(8'h55, 1'b0);
        mdl_break();
        idle(2 * CPB);
        tx(8'hA1); tx(8'h00); tx(8'h07);
        wait_idle("stoperr");
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stoperr_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
        end else foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stoperr_val[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_err != exp_err) begin n_fail++; $display("FAIL stoperr_err: got %0d required %0d", got_err, exp_err); end
    endtask

    task automatic test_timeout();
        start_test();
        tx(8'hA1); tx(8'h00);
        idle(40);
        mdl_break();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b required 0", busy); end
        tx(8'h0A);
        wait_idle("timeout");
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL timeout_count: got %0d strobes required 0", got_q.size()); end
        n_cmp++; if (got_err != exp_err) begin n_fail++; $display("FAIL timeout_err: got %0d required %0d", got_err, exp_err); end
    endtask

    task automatic test_glitch_and_reset();
        start_test();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(3 * CPB);
        n_cmp++; if (got_q.size() != 0 || got_err != 0) begin
            n_fail++; $display("FAIL glitch: got %0d strobes %0d errors required 0 and 0", got_q.size(), got_err);
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b required 0", busy); end
        tx(8'hA1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        reset = 1'b0; rx = 1'b1;
        pend.delete();
        @(negedge clk);
        n_cmp++; if (uart_en !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pulses: got en=%b err=%b required 0 0", uart_en, frame_err);
        end
        n_cmp++; if ({uart_sel, uart_data} !== 18'h0) begin
            n_fail++; $display("FAIL midreset_outs: got %h required 00000", {uart_sel, uart_data});
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", busy); end
        reset = 1'b1;
        idle(2 * CPB);
        tx(8'hA1); tx(8'h00); tx(8'h05);
        wait_idle("reset");
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL reset_frame_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
        end else foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL reset_frame_val[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_err != exp_err) begin n_fail++; $display("FAIL reset_frame_err: got %0d required %0d", got_err, exp_err); end
    endtask

    task automatic test_random_back_to_back();
        int         kind;
        logic [7:0] b;
        start_test();
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                b = 8'($urandom);
                if (b[7:2] == 6'b101000) b[7] = 1'b0;
                tx(b);
            end else begin
                for (int j = 0; j < 3; j++) begin
                    if (j == 0) b = {6'b101000, 2'($urandom)};
                    else b = 8'($urandom);
                    if (kind == 4 && j == 1) begin
                        idle(60);
                        if (pend.size() != 0) mdl_break();
                    end
                    tx(b);
                    if (kind == 3) idle($urandom_range(0, 10));
                end
            end
        end
        if (pend.size() != 0) mdl_break();
        wait_idle("random");
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
        end else foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_val[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_err != exp_err) begin n_fail++; $display("FAIL random_err: got %0d required %0d", got_err, exp_err); end
    endtask

    task automatic test_integrity();
        n_cmp++; if (err_wide != 0) begin n_fail++; $display("FAIL err_width: got %0d wide pulses required 0", err_wide); end
        n_cmp++; if (hold_viol != 0) begin n_fail++; $display("FAIL output_hold: got %0d changes without strobe required 0", hold_viol); end
    endtask

    initial begin
        reset = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_two_frames();
        test_bad_header();
        test_stop_err();
        test_timeout();
        test_glitch_and_reset();
        test_random_back_to_back();
        test_integrity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
